fetch_stage: RTL and testbench

Instruction-fetch stage that drives the program counter and the instruction-memory request port, and delivers instruction/PC pairs to decode. It sits directly upstream of the hazards controller and takes that controller's `stall`, `data_hazard` and `control_hazard` outputs. It also takes the execute stage's `jump_taken`/`jump_target`. A one-entry hold buffer keeps fetched instructions that arrive while the pipeline cannot advance, so they are not lost.

---
 rtl/fetch_stage.sv | 105 ++++++++++
 tb/tb_fetch_stage.sv | 130 +++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the instruction-memory request,
// and parks one early response in a hold buffer while decode cannot accept it.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        jump_taken,
  input  logic [31:0] jump_target,
  input  logic        stall,
  input  logic        data_hazard,
  input  logic        control_hazard,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_valid
);

  typedef enum logic {REQ = 1'b0, HOLD = 1'b1} state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] hold_inst;
  logic [31:0] hold_pc;
  logic        hold_valid;
  logic        adv;
  logic        capture;
  logic        park;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

  function automatic logic [31:0] next_pc(input logic [31:0] cur);
    return cur + 32'd4;
  endfunction

  assign adv       = ~stall & ~data_hazard & ~control_hazard;
  assign imem_req  = (state == REQ) & ~rst;
  assign imem_addr = pc;
  assign capture   = (state == REQ) & imem_ready & ~jump_taken;
  assign park      = capture & ~adv;

  // Control and output registers; jump redirect wins over every other event.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= REQ;
      pc         <= RESET_PC;
      inst       <= NOP_INST;
      inst_pc    <= 32'h0;
      inst_valid <= 1'b0;
      hold_valid <= 1'b0;
    end else if (jump_taken) begin
      state      <= REQ;
      pc         <= align_word(jump_target);
      hold_valid <= 1'b0;
      inst       <= NOP_INST;
      inst_valid <= 1'b0;
    end else begin
      case (state)
        REQ: begin
          if (imem_ready) begin
            pc <= next_pc(pc);
            if (adv) begin
              inst       <= imem_rdata;
              inst_pc    <= pc;
              inst_valid <= 1'b1;
            end else begin
              hold_valid <= 1'b1;
              state      <= HOLD;
            end
          end
        end
        HOLD: begin
          if (adv && hold_valid) begin
            inst       <= hold_inst;
            inst_pc    <= hold_pc;
            inst_valid <= 1'b1;
            hold_valid <= 1'b0;
            state      <= REQ;
          end
        end
        default: state <= REQ;
      endcase
      // A flush turns decode's slot into a bubble; stall/data_hazard just freeze it.
      if (control_hazard) begin
        inst       <= NOP_INST;
        inst_valid <= 1'b0;
      end
    end
  end

  // Hold-buffer payload carries no reset; hold_valid qualifies it.
  always_ff @(posedge clk) begin
    if (park) begin
      hold_inst <= imem_rdata;
      hold_pc   <= pc;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage; memory returns the request address as data.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        jump_taken;
  logic [31:0] jump_target;
  logic        stall;
  logic        data_hazard;
  logic        control_hazard;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_valid;

  int checks = 0;
  int failures = 0;

  fetch_stage dut (
    .clk            (clk),
    .rst            (rst),
    .jump_taken     (jump_taken),
    .jump_target    (jump_target),
    .stall          (stall),
    .data_hazard    (data_hazard),
    .control_hazard (control_hazard),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .imem_ready     (imem_ready),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .inst_valid     (inst_valid)
  );

  always #5 clk = ~clk;
  assign imem_rdata = imem_addr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic req, input logic [31:0] addr,
                         input logic [31:0] i, input logic [31:0] ipc, input logic v);
    chk({tag, ".req"}, {31'h0, imem_req}, {31'h0, req});
    chk({tag, ".addr"}, imem_addr, addr);
    chk({tag, ".inst"}, inst, i);
    chk({tag, ".inst_pc"}, inst_pc, ipc);
    chk({tag, ".valid"}, {31'h0, inst_valid}, {31'h0, v});
  endtask

  initial begin
    rst = 1'b1; jump_taken = 1'b0; jump_target = 32'h0; stall = 1'b0;
    data_hazard = 1'b0; control_hazard = 1'b0; imem_ready = 1'b0;
    #1;
    chk_out("reset", 1'b0, 32'h0, NOP, 32'h0, 1'b0);
    tick(); tick();
    rst = 1'b0;
    imem_ready = 1'b1;
    #1;
    chk_out("first_req", 1'b1, 32'h0, NOP, 32'h0, 1'b0);

    // Streaming fetch
    tick(); chk_out("fetch0", 1'b1, 32'h4, 32'h0, 32'h0, 1'b1);
    tick(); chk_out("fetch4", 1'b1, 32'h8, 32'h4, 32'h4, 1'b1);

    // Two wait states at 0x8
    imem_ready = 1'b0;
    tick(); chk_out("wait1", 1'b1, 32'h8, 32'h4, 32'h4, 1'b1);
    tick(); chk_out("wait2", 1'b1, 32'h8, 32'h4, 32'h4, 1'b1);
    imem_ready = 1'b1;
    tick(); chk_out("fetch8", 1'b1, 32'hC, 32'h8, 32'h8, 1'b1);

    // data_hazard for two cycles while 0xC completes
    data_hazard = 1'b1;
    tick(); chk_out("dh_park", 1'b0, 32'h10, 32'h8, 32'h8, 1'b1);
    tick(); chk_out("dh_hold", 1'b0, 32'h10, 32'h8, 32'h8, 1'b1);
    data_hazard = 1'b0;
    tick(); chk_out("dh_release", 1'b1, 32'h10, 32'hC, 32'hC, 1'b1);
    tick(); chk_out("fetch10", 1'b1, 32'h14, 32'h10, 32'h10, 1'b1);
    tick(); tick(); tick();
    chk_out("fetch1c", 1'b1, 32'h20, 32'h1C, 32'h1C, 1'b1);

    // Jump to 0x103 colliding with the 0x20 response
    jump_taken = 1'b1; jump_target = 32'h103;
    tick(); chk_out("jump_n1", 1'b1, 32'h100, NOP, 32'h1C, 1'b0);
    jump_taken = 1'b0; control_hazard = 1'b1;
    tick(); chk_out("jump_n2", 1'b0, 32'h104, NOP, 32'h1C, 1'b0);
    control_hazard = 1'b0;
    tick(); chk_out("jump_n3", 1'b1, 32'h104, 32'h100, 32'h100, 1'b1);

    // Jump to top of address space, PC wraps to 0
    jump_taken = 1'b1; jump_target = 32'hFFFF_FFFC;
    tick(); chk_out("wrap_jump", 1'b1, 32'hFFFF_FFFC, NOP, 32'h100, 1'b0);
    jump_taken = 1'b0;
    tick(); chk_out("wrap_top", 1'b1, 32'h0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b1);
    tick(); chk_out("wrap_zero", 1'b1, 32'h4, 32'h0, 32'h0, 1'b1);

    // Reset asserted mid-cycle while the hold buffer is occupied
    data_hazard = 1'b1;
    tick(); chk_out("pre_rst_hold", 1'b0, 32'h8, 32'h0, 32'h0, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk_out("async_rst", 1'b0, 32'h0, NOP, 32'h0, 1'b0);
    data_hazard = 1'b0;
    tick(); chk_out("rst_held", 1'b0, 32'h0, NOP, 32'h0, 1'b0);
    rst = 1'b0;
    #1;
    chk_out("restart_req", 1'b1, 32'h0, NOP, 32'h0, 1'b0);
    tick(); chk_out("restart_fetch", 1'b1, 32'h4, 32'h0, 32'h0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
